// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// the default MEM wait limit.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } ctrl_state_e;

  localparam int unsigned WAIT_MAX_DEF = 255;
endpackage

// File: rtl/sat_counter32.sv
// 32-bit up counter with enable that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        inc,
  output logic [31:0] cnt
);
  // Written every cycle so the register always reflects its own current value.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) cnt <= '0;
    else         cnt <= cnt + {31'd0, (inc && !(&cnt))};
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: MEM bus-wait freeze with timeout
// fault, load-use interlock, taken-branch flush and stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_re1,
  input  logic        id_re2,
  input  logic [4:0]  ex_wR,
  input  logic        ex_rf_we,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_bubble,
  output logic        bus_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  ctrl_state_e state, state_nxt;
  logic [7:0]  wcnt, wcnt_nxt;
  logic        mem_hold, freeze, load_use;

  assign mem_hold = mem_req && !mem_ready && (state != FAULT);
  assign freeze   = mem_hold || (state == FAULT);
  assign load_use = ex_is_load && ex_rf_we && (ex_wR != 5'd0) &&
                    ((id_re1 && id_rs1 == ex_wR) || (id_re2 && id_rs2 == ex_wR));

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state   <= RUN;
      wcnt    <= 8'd0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      wcnt    <= wcnt_nxt;
      if (state_nxt == FAULT) bus_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      RUN: if (mem_hold) begin
        state_nxt = WAIT;
        wcnt_nxt  = 8'd1;
      end
      WAIT: begin
        if (!mem_hold) begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end else if (wcnt == WAIT_LIM) begin
          state_nxt = FAULT;
          wcnt_nxt  = 8'd0;
        end else begin
          wcnt_nxt  = wcnt + 8'd1;
        end
      end
      FAULT: state_nxt = FAULT;
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase
  end

  // Freeze beats branch beats load-use; a branch seen during freeze stays
  // in EX and is flushed once the freeze lifts.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (freeze) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  sat_counter32 u_stall_cnt (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .inc     (pc_stall),
    .cnt     (stall_cnt)
  );

  sat_counter32 u_flush_cnt (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .inc     (if_id_flush),
    .cnt     (flush_cnt)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: interlock, branch, MEM wait,
// timeout fault, reset recovery and counter saturation.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [4:0]  id_rs1, id_rs2, ex_wR;
  logic        id_re1, id_re2, ex_rf_we, ex_is_load, ex_branch_taken;
  logic        mem_req, mem_ready;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, mem_wb_bubble, bus_err;
  logic [31:0] stall_cnt, flush_cnt;

  int nvec = 0;
  int nerr = 0;

  // {pc, if_id, id_ex, ex_mem stalls, if_id_flush, id_ex_flush, mem_wb_bubble}
  logic [6:0] ctl;
  assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, mem_wb_bubble};
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_FRZ  = 7'b1111001;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;

  always #5 cpu_clk = ~cpu_clk;

  pipe_hazard_ctrl dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
    .bus_err(bus_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_re1 = 1'b0; id_re2 = 1'b0;
    ex_wR = 5'd0; ex_rf_we = 1'b0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  // Inputs change just after a falling edge; outputs are sampled #1 later.
  task automatic settle();
    @(negedge cpu_clk);
    #1;
  endtask

  task automatic load_use_rs1();
    idle();
    ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_wR = 5'd5;
    id_re1 = 1'b1; id_rs1 = 5'd5;
  endtask

  task automatic test_reset();
    idle();
    cpu_rst = 1'b1;
    settle();
    nvec++; if (ctl !== C_NONE) begin nerr++; $display("FAIL reset_ctl got %b want %b", ctl, C_NONE); end
    nvec++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin nerr++; $display("FAIL reset_cnt got %h/%h want 0/0", stall_cnt, flush_cnt); end
    nvec++; if (bus_err !== 1'b0) begin nerr++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
    nvec++; if (dut.state !== RUN) begin nerr++; $display("FAIL reset_state got %0d want 0", dut.state); end
    cpu_rst = 1'b0;
  endtask

  task automatic test_load_use();
    settle();
    load_use_rs1();
    #1;
    nvec++; if (ctl !== C_LU) begin nerr++; $display("FAIL lu_rs1_ctl got %b want %b", ctl, C_LU); end
    nvec++; if (stall_cnt !== 32'd0) begin nerr++; $display("FAIL lu_cnt_pre got %0d want 0", stall_cnt); end
    @(posedge cpu_clk); #1;
    nvec++; if (stall_cnt !== 32'd1) begin nerr++; $display("FAIL lu_cnt_post got %0d want 1", stall_cnt); end
    settle();
    idle();
    ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_wR = 5'd17;
    id_re2 = 1'b1; id_rs2 = 5'd17; id_re1 = 1'b1; id_rs1 = 5'd3;
    #1;
    nvec++; if (ctl !== C_LU) begin nerr++; $display("FAIL lu_rs2_ctl got %b want %b", ctl, C_LU); end
    settle();
    idle();
    #1;
    nvec++; if (ctl !== C_NONE) begin nerr++; $display("FAIL lu_release_ctl got %b want %b", ctl, C_NONE); end
    nvec++; if (stall_cnt !== 32'd2) begin nerr++; $display("FAIL lu_cnt2 got %0d want 2", stall_cnt); end
  endtask

  task automatic test_no_stall();
    logic [4:0] vec [4][3];
    // each row: {ex_wR, id_rs1, {ex_is_load,ex_rf_we,id_re1}}
    vec[0] = '{5'd0, 5'd0, 5'b00111};
    vec[1] = '{5'd5, 5'd5, 5'b00110};
    vec[2] = '{5'd5, 5'd5, 5'b00101};
    vec[3] = '{5'd5, 5'd5, 5'b00011};
    for (int i = 0; i < 4; i++) begin
      settle();
      idle();
      ex_wR = vec[i][0]; id_rs1 = vec[i][1];
      ex_is_load = vec[i][2][2]; ex_rf_we = vec[i][2][1]; id_re1 = vec[i][2][0];
      #1;
      nvec++; if (ctl !== C_NONE) begin nerr++; $display("FAIL no_stall_%0d got %b want %b", i, ctl, C_NONE); end
    end
    settle();
    idle();
    nvec++; if (stall_cnt !== 32'd2) begin nerr++; $display("FAIL no_stall_cnt got %0d want 2", stall_cnt); end
  endtask

  task automatic test_branch();
    settle();
    load_use_rs1();
    ex_branch_taken = 1'b1;
    #1;
    nvec++; if (ctl !== C_BR) begin nerr++; $display("FAIL br_lu_ctl got %b want %b", ctl, C_BR); end
    @(posedge cpu_clk); #1;
    nvec++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd2) begin nerr++; $display("FAIL br_cnt got %0d/%0d want 1/2", flush_cnt, stall_cnt); end
  endtask

  // Three wait cycles with a taken branch held in EX; flush fires once freed.
  task automatic test_mem_wait();
    settle();
    idle();
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (ctl !== C_FRZ) begin nerr++; $display("FAIL wait_ctl_%0d got %b want %b", i, ctl, C_FRZ); end
      @(posedge cpu_clk); #1;
      nvec++; if (dut.state !== WAIT) begin nerr++; $display("FAIL wait_state_%0d got %0d want 1", i, dut.state); end
      @(negedge cpu_clk);
    end
    mem_ready = 1'b1;
    #1;
    nvec++; if (ctl !== C_BR) begin nerr++; $display("FAIL wait_defer_br got %b want %b", ctl, C_BR); end
    @(posedge cpu_clk); #1;
    nvec++; if (dut.state !== RUN) begin nerr++; $display("FAIL wait_exit_state got %0d want 0", dut.state); end
    nvec++; if (stall_cnt !== 32'd5 || flush_cnt !== 32'd2) begin nerr++; $display("FAIL wait_cnt got %0d/%0d want 5/2", stall_cnt, flush_cnt); end
  endtask

  task automatic test_fault();
    int bad = 0;
    settle();
    idle();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (ctl !== C_FRZ) bad++;
      @(posedge cpu_clk); #1;
      nvec++;
      if (bus_err !== (i == 255)) begin nerr++; $display("FAIL fault_bus_err_cyc%0d got %b want %b", i, bus_err, (i == 255)); end
      @(negedge cpu_clk);
    end
    nvec++; if (bad != 0) begin nerr++; $display("FAIL fault_freeze got %0d bad cycles want 0", bad); end
    nvec++; if (dut.state !== FAULT) begin nerr++; $display("FAIL fault_state got %0d want 2", dut.state); end
    mem_req = 1'b0; mem_ready = 1'b1;
    #1;
    nvec++; if (ctl !== C_FRZ) begin nerr++; $display("FAIL fault_hold_ctl got %b want %b", ctl, C_FRZ); end
    nvec++; if (stall_cnt !== 32'd261) begin nerr++; $display("FAIL fault_stall_cnt got %0d want 261", stall_cnt); end
    cpu_rst = 1'b1;
    #1;
    nvec++; if (bus_err !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin nerr++; $display("FAIL fault_rst got %b/%0d/%0d want 0/0/0", bus_err, stall_cnt, flush_cnt); end
    settle();
    cpu_rst = 1'b0;
    settle();
    nvec++; if (ctl !== C_NONE || dut.state !== RUN) begin nerr++; $display("FAIL fault_recover got %b/%0d want %b/0", ctl, dut.state, C_NONE); end
  endtask

  task automatic test_rst_mid_wait();
    settle();
    mem_req = 1'b1; mem_ready = 1'b0;
    @(posedge cpu_clk); @(posedge cpu_clk); #1;
    cpu_rst = 1'b1;
    #1;
    nvec++; if (dut.state !== RUN || dut.wcnt !== 8'd0) begin nerr++; $display("FAIL midwait_rst got %0d/%0d want 0/0", dut.state, dut.wcnt); end
    settle();
    idle();
    cpu_rst = 1'b0;
    settle();
    nvec++; if (ctl !== C_NONE || stall_cnt !== 32'd0) begin nerr++; $display("FAIL midwait_recover got %b/%0d want %b/0", ctl, stall_cnt, C_NONE); end
  endtask

  task automatic test_saturate();
    settle();
    idle();
    force dut.u_stall_cnt.cnt = 32'hFFFF_FFFE;
    @(posedge cpu_clk); #1;
    release dut.u_stall_cnt.cnt;
    #1;
    nvec++; if (stall_cnt !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL sat_preset got %h want fffffffe", stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      settle();
      load_use_rs1();
      @(posedge cpu_clk); #1;
      nvec++; if (stall_cnt !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL sat_step_%0d got %h want ffffffff", i, stall_cnt); end
    end
    settle();
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_wait();
    test_fault();
    test_rst_mid_wait();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port cpu_clk  input  1  single pipeline clock, rising edge active.
REQ-002 SHALL have port cpu_rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have ports id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-004 SHALL have ports id_re1, id_re2  input  1 each  ID instruction actually reads rs1 / rs2.
REQ-005 SHALL have ports ex_wR  input  5, ex_rf_we  input  1, ex_is_load  input  1  destination, write-enable and load flag of the instruction in EX.
REQ-006 SHALL have port ex_branch_taken  input  1  EX resolved a taken branch/jump (PC redirect).
REQ-007 SHALL have ports mem_req  input  1, mem_ready  input  1  MEM-stage bus access request and bus completion.
REQ-008 SHALL have outputs pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  1 each  hold the PC / pipeline register.
REQ-009 SHALL have outputs if_id_flush, id_ex_flush, mem_wb_bubble  1 each  load a bubble (rf_we=0, ram_we=0, inst_valid=0).
REQ-010 SHALL have outputs bus_err  1  sticky timeout flag; stall_cnt, flush_cnt  32 each  performance counters.
REQ-011 SHALL have parameter WAIT_MAX, default 255, meaning maximum MEM wait cycles before fault.

Function
REQ-012 SHALL implement FSM states RUN, WAIT, FAULT; reset state RUN.
REQ-013 SHALL define mem_hold = mem_req && !mem_ready, combinational, in RUN or WAIT.
REQ-014 SHALL transition RUN->WAIT on mem_hold; WAIT->RUN on mem_ready; WAIT->FAULT when the wait counter equals WAIT_MAX with mem_hold still true; FAULT exits only on reset.
REQ-015 SHALL load the 8-bit wait counter with 1 on RUN->WAIT, increment it each WAIT cycle and clear it on leaving WAIT.
REQ-016 SHALL, when freeze = mem_hold or state==FAULT, assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_bubble in the same cycle, and deassert all flushes.
REQ-017 SHALL detect load-use = ex_is_load && ex_rf_we && ex_wR!=0 && ((id_re1 && id_rs1==ex_wR) || (id_re2 && id_rs2==ex_wR)).
REQ-018 SHALL, on load-use without freeze or branch, assert pc_stall, if_id_stall and id_ex_flush for exactly that cycle; ex_mem_stall=0.
REQ-019 SHALL, on ex_branch_taken without freeze, assert if_id_flush and id_ex_flush, no stalls; branch has priority over load-use.
REQ-020 SHALL defer a branch during freeze: the EX instruction is held, so the flush fires in the first non-frozen cycle.
REQ-021 SHALL drive all control outputs low in the no-hazard case; control outputs are combinational from state and inputs (zero latency).
REQ-022 SHALL increment stall_cnt on each clock edge where pc_stall=1, and flush_cnt on each edge where if_id_flush=1; both saturate at 0xFFFF_FFFF.
REQ-023 SHALL set bus_err on entry to FAULT and hold it until reset.

Reset
REQ-024 SHALL, on cpu_rst, immediately force state RUN, wait counter 0, bus_err 0, stall_cnt 0, flush_cnt 0.
REQ-025 SHALL, with cpu_rst asserted mid-WAIT or in FAULT, return to RUN and, after release, produce only input-derived outputs (all low with idle inputs).

Structure
REQ-026 SHALL place state encoding (RUN=2'd0, WAIT=2'd1, FAULT=2'd2) and the WAIT_MAX default in shared package pipe_ctrl_pkg.
REQ-027 SHALL instantiate sub-module sat_counter32 (async reset, inc enable, saturating) twice for the performance counters.

Verification
REQ-028 SHALL test load-use: ex_is_load=1, ex_rf_we=1, ex_wR=5, id_re1=1, id_rs1=5 -> one cycle pc_stall=if_id_stall=id_ex_flush=1, stall_cnt 0->1.
REQ-029 SHALL test x0 and no-read cases: ex_wR=0 or id_re1=0 with matching index -> no stall.
REQ-030 SHALL test branch plus load-use in the same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0, flush_cnt +1.
REQ-031 SHALL test mem_req=1, mem_ready low for 3 cycles -> all stalls and mem_wb_bubble high for 3 cycles, state RUN->WAIT->RUN, stall_cnt +3.
REQ-032 SHALL test mem_ready held low for WAIT_MAX+1 cycles -> FAULT, bus_err=1 and stalls held; cpu_rst pulse -> RUN, bus_err=0, counters 0.
REQ-033 SHALL test stall_cnt forced to 0xFFFF_FFFE with three stall cycles -> value 0xFFFF_FFFF, no wrap.
